// File: rtl/mux_sel_stage.sv
// mux_sel_stage: registered N:1 operand select with a two-entry skid buffer and registered in_ready
module mux_sel_stage #(
    parameter  int WIDTH  = 64,
    parameter  int NUM_IN = 4,
    localparam int SEL_W  = (NUM_IN > 1) ? $clog2(NUM_IN) : 1
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [NUM_IN*WIDTH-1:0] data_in,
    input  logic [SEL_W-1:0]        sel,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    flush,
    output logic [WIDTH-1:0]        out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    sel_err
);
    logic [WIDTH-1:0] main_q, main_d, skid_q, skid_d, sel_val;
    logic             main_vld_q, main_vld_d, skid_vld_q, skid_vld_d, err_q, err_d;
    logic             accept, drain, sel_oob;

    // in_ready depends only on the skid flag, so no path from out_ready reaches it
    assign accept  = in_valid && !skid_vld_q;
    assign drain   = main_vld_q && out_ready;
    assign sel_oob = int'(sel) >= NUM_IN;

    // Source decode; an index outside the source range leaves the value at zero
    always_comb begin
        sel_val = '0;
        for (int k = 0; k < NUM_IN; k++)
            if (sel == SEL_W'(k)) sel_val = data_in[k*WIDTH +: WIDTH];
    end

    // Next state: flush empties both entries, otherwise main refills from skid first to keep FIFO order
    always_comb begin
        main_d     = main_q;
        main_vld_d = main_vld_q;
        skid_d     = skid_q;
        skid_vld_d = skid_vld_q;
        err_d      = err_q | (accept && !flush && sel_oob);
        if (flush) begin
            main_vld_d = 1'b0;
            skid_vld_d = 1'b0;
            skid_d     = '0;
        end else if (!main_vld_q || drain) begin
            if (skid_vld_q) begin
                main_d     = skid_q;
                main_vld_d = 1'b1;
                skid_d     = '0;
                skid_vld_d = 1'b0;
            end else begin
                main_vld_d = accept;
                main_d     = accept ? sel_val : main_q;
            end
        end else if (accept) begin
            skid_d     = sel_val;
            skid_vld_d = 1'b1;
        end
    end

    // State registers; reset clears everything immediately, dropping any held beats
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            main_q     <= '0;
            main_vld_q <= 1'b0;
            skid_q     <= '0;
            skid_vld_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            main_q     <= main_d;
            main_vld_q <= main_vld_d;
            skid_q     <= skid_d;
            skid_vld_q <= skid_vld_d;
            err_q      <= err_d;
        end
    end

    assign in_ready  = !skid_vld_q;
    assign out_data  = main_q;
    assign out_valid = main_vld_q;
    assign sel_err   = err_q;
endmodule

// File: tb/tb_mux_sel_stage.sv
// tb_mux_sel_stage: directed and random checks of mux_sel_stage against a two-deep queue model
module tb_mux_sel_stage;
    localparam int W = 64;
    logic clk = 1'b0, reset_n = 1'b0;
    logic [4*W-1:0] data_in;
    logic [1:0] sel;
    logic in_valid, flush, out_ready;
    logic a_in_ready, a_out_valid, a_sel_err, b_in_ready, b_out_valid, b_sel_err;
    logic [W-1:0] a_out_data, b_out_data;
    logic [W-1:0] qa[$], qb[$];
    logic [W-1:0] la, lb;
    logic eb;
    int checks = 0, errors = 0, dut_xfers = 0, t0;
    logic [W-1:0] exp4[4];

    always #5 clk = ~clk;

    mux_sel_stage #(.WIDTH(W), .NUM_IN(4)) u_a (
        .clk(clk), .reset_n(reset_n), .data_in(data_in), .sel(sel), .in_valid(in_valid),
        .in_ready(a_in_ready), .flush(flush), .out_data(a_out_data), .out_valid(a_out_valid),
        .out_ready(out_ready), .sel_err(a_sel_err));

    mux_sel_stage #(.WIDTH(W), .NUM_IN(3)) u_b (
        .clk(clk), .reset_n(reset_n), .data_in(data_in[3*W-1:0]), .sel(sel), .in_valid(in_valid),
        .in_ready(b_in_ready), .flush(flush), .out_data(b_out_data), .out_valid(b_out_valid),
        .out_ready(out_ready), .sel_err(b_sel_err));

    always @(posedge clk) if (reset_n && a_out_valid && out_ready) dut_xfers <= dut_xfers + 1;

    function automatic logic [W-1:0] pick(input int n, input logic [1:0] s);
        return (int'(s) < n) ? data_in[int'(s)*W +: W] : '0;
    endfunction

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        qa.delete(); qb.delete(); la = '0; lb = '0; eb = 1'b0;
    endtask

    task automatic model_edge();
        bit acc, drn;
        acc = in_valid && qa.size() < 2;
        drn = qa.size() > 0 && out_ready;
        if (drn) begin void'(qa.pop_front()); void'(qb.pop_front()); end
        if (flush) begin qa.delete(); qb.delete(); end
        else if (acc) begin
            qa.push_back(pick(4, sel));
            qb.push_back(pick(3, sel));
            if (sel == 2'd3) eb = 1'b1;
        end
        if (qa.size() > 0) begin la = qa[0]; lb = qb[0]; end
    endtask

    task automatic check_all();
        chk("a_valid", W'(a_out_valid), W'(qa.size() > 0));
        chk("a_ready", W'(a_in_ready), W'(qa.size() < 2));
        chk("a_data", a_out_data, la);
        chk("a_err", W'(a_sel_err), '0);
        chk("b_valid", W'(b_out_valid), W'(qb.size() > 0));
        chk("b_ready", W'(b_in_ready), W'(qb.size() < 2));
        chk("b_data", b_out_data, lb);
        chk("b_err", W'(b_sel_err), W'(eb));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_all();
    endtask

    task automatic rand_data();
        for (int k = 0; k < 4; k++) data_in[k*W +: W] = {$urandom, $urandom};
    endtask

    task automatic send_until();
        bit acc;
        for (int i = 0; i < 8; i++) begin
            acc = qa.size() < 2;
            step();
            if (acc) break;
        end
        in_valid = 1'b0;
    endtask

    task automatic fill_two();
        out_ready = 1'b0; in_valid = 1'b1;
        rand_data(); sel = 2'($urandom_range(0, 2)); step();
        rand_data(); sel = 2'($urandom_range(0, 2)); step();
        in_valid = 1'b0;
    endtask

    initial begin
        data_in = '0; sel = '0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
        model_reset();
        #12 check_all();
        @(negedge clk) reset_n = 1'b1;
        step();

        exp4 = '{64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                 64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
        for (int k = 0; k < 4; k++) data_in[k*W +: W] = {16{4'(4 - k)}};
        out_ready = 1'b1; in_valid = 1'b1;
        for (int s = 0; s < 4; s++) begin
            sel = 2'(s);
            step();
            chk("basic_data", a_out_data, exp4[s]);
        end
        in_valid = 1'b0;
        step();

        out_ready = 1'b0; in_valid = 1'b1;
        rand_data(); sel = 2'd1; step();
        rand_data(); sel = 2'd2; step();
        chk("stall_in_ready", W'(a_in_ready), '0);
        rand_data(); sel = 2'd0; step(); step();
        out_ready = 1'b1;
        send_until();
        for (int i = 0; i < 3; i++) step();
        chk("stall_drained", W'(a_out_valid), '0);

        fill_two();
        rand_data(); in_valid = 1'b1; flush = 1'b1; step();
        flush = 1'b0; in_valid = 1'b0;
        chk("flush_valid", W'(a_out_valid), '0);
        chk("flush_ready", W'(a_in_ready), 64'd1);
        step();
        rand_data(); sel = 2'd2; in_valid = 1'b1; out_ready = 1'b1; step();
        in_valid = 1'b0;
        chk("flush_e_data", a_out_data, data_in[2*W +: W]);
        step();

        fill_two();
        t0 = dut_xfers;
        out_ready = 1'b1; flush = 1'b1; step();
        flush = 1'b0;
        chk("flush_drain_xfer", W'(dut_xfers - t0), 64'd1);
        chk("flush_drain_valid", W'(a_out_valid), '0);
        step();

        rand_data(); sel = 2'd3; in_valid = 1'b1; out_ready = 1'b1; step();
        in_valid = 1'b0;
        chk("oob_data", b_out_data, '0);
        chk("oob_err", W'(b_sel_err), 64'd1);
        flush = 1'b1; step(); flush = 1'b0;
        chk("oob_err_flush", W'(b_sel_err), 64'd1);
        step();

        fill_two();
        #2 reset_n = 1'b0;
        #1;
        chk("areset_valid", W'(a_out_valid), '0);
        chk("areset_ready", W'(a_in_ready), 64'd1);
        chk("areset_err", W'(b_sel_err), '0);
        model_reset();
        check_all();
        @(negedge clk) reset_n = 1'b1;
        step();

        for (int i = 0; i < 400; i++) begin
            rand_data();
            sel = 2'($urandom);
            in_valid = ($urandom % 4) != 0;
            out_ready = ($urandom % 3) != 0;
            flush = ($urandom % 20) == 0;
            step();
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
